// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath helpers: GF(2^8) arithmetic, state byte/column
// indexing and the FSM state type for the inverse linear round.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = gf_xtime(a);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(a));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // MSB position of byte (4*col + row); byte 0 sits at [127:120].
  function automatic logic [6:0] byte_msb(input logic [1:0] col, input logic [1:0] row);
    return 7'd127 - {col, row, 3'b000};
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] col);
    return s[byte_msb(col, 2'd0) -: 32];
  endfunction

endpackage

// File: rtl/aes_inv_round_linear_if.sv
// Block-in / block-out handshake bundle of the inverse linear round.
interface aes_inv_round_linear_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_skip_mix;
  logic         in_skip_shift;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, in_key, in_skip_mix, in_skip_shift, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_key, in_skip_mix, in_skip_shift, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_i[31-8*r -: 8];
    assign col_o[31-8*r -: 8] = gf_mul14(a[r])       ^ gf_mul11(a[(r+1)%4]) ^
                                gf_mul13(a[(r+2)%4]) ^ gf_mul9(a[(r+3)%4]);
  end

endmodule

// File: rtl/aes_inv_round_linear.sv
// AddRoundKey -> column-serial InvMixColumns -> InvShiftRows, one block at a time.
module aes_inv_round_linear
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_round_linear_if.slave bus
);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_data_q, out_data_d;
  logic         skip_mix_q, skip_mix_d;
  logic         skip_shift_q, skip_shift_d;

  logic         accept;
  logic [31:0]  mix_out;
  logic [127:0] key_added, mixed_work, shift_src, shifted;
  logic         shift_en;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[byte_msb(2'(c), 2'(row)) -: 8] = s[byte_msb(2'(c - row), 2'(row)) -: 8];
    return r;
  endfunction

  aes_inv_mix_column u_mix (
    .col_i (get_col(work_q, col_q)),
    .col_o (mix_out)
  );

  assign key_added = bus.in_data ^ bus.in_key;
  assign accept    = bus.in_valid && bus.in_ready;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = bus.in_skip_mix ? DONE : BUSY;
      BUSY:    if (col_q == 2'd3) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; in_ready is held low for the whole reset cycle.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.out_data  = out_data_q;
  end

  // Datapath: the single shifter serves both the bypass and the post-mix result.
  always_comb begin
    mixed_work = work_q;
    mixed_work[byte_msb(col_q, 2'd0) -: 32] = mix_out;
    shift_src  = (state_q == IDLE) ? key_added : mixed_work;
    shift_en   = (state_q == IDLE) ? !bus.in_skip_shift : !skip_shift_q;
    shifted    = shift_en ? inv_shift_rows(shift_src) : shift_src;

    work_d       = work_q;
    col_d        = col_q;
    out_data_d   = out_data_q;
    skip_mix_d   = skip_mix_q;
    skip_shift_d = skip_shift_q;

    if (state_q == IDLE && accept) begin
      work_d       = key_added;
      col_d        = 2'd0;
      skip_mix_d   = bus.in_skip_mix;
      skip_shift_d = bus.in_skip_shift;
      if (bus.in_skip_mix) out_data_d = shifted;
    end else if (state_q == BUSY) begin
      work_d = mixed_work;
      col_d  = col_q + 2'd1;
      if (col_q == 2'd3) out_data_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      work_q       <= '0;
      out_data_q   <= '0;
      skip_mix_q   <= 1'b0;
      skip_shift_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      work_q       <= work_d;
      out_data_q   <= out_data_d;
      skip_mix_q   <= skip_mix_d;
      skip_shift_q <= skip_shift_d;
    end
  end

endmodule

// File: doc/aes_inv_round_linear.md
# aes_inv_round_linear

Linear half of one AES inverse-cipher round: AddRoundKey, then InvMixColumns (column-serial, one column per cycle), then InvShiftRows, on a 128-bit state with a valid/ready handshake on both sides. It sits in the decryption datapath between the round-key source and the InvSubBytes stage. It is the decrypt-side counterpart of the encrypt-side ShiftRow/MixColumns path and uses the same byte layout: byte 0 at [127:120], column c = bytes 4c..4c+3, row r of column c = byte 4c+r.

## Interface
- No parameters; widths fixed by AES.
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input block valid
- in_ready  out  1  block accepts input
- in_data  in  128  state after previous InvSubBytes (or ciphertext)
- in_key  in  128  round key
- in_skip_mix  in  1  1 = bypass InvMixColumns (first/last key addition)
- in_skip_shift  in  1  1 = bypass InvShiftRows (final round-0 key addition)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  result state

## Operation
- Result = S(M(in_data ^ in_key)). M = InvMixColumns unless skip_mix. S = InvShiftRows unless skip_shift.
- InvShiftRows: out[r][c] = in[r][(c − r) mod 4].
- InvMixColumns per column (a0..a3): b_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), indices mod 4, GF(2^8) modulo 0x11b, built from xtime chains. No multiplier tables.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register work = in_data^in_key and latch both skip flags. If skip_mix, go to DONE with out_data = S(work). Otherwise go to BUSY with col=0.
  - BUSY: each cycle, replace column col of work with its InvMixColumns; col increments as a 2-bit counter. At col==3, go to DONE and register out_data = S(updated work).
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready=1 only in IDLE. There is no overlap of consecutive blocks.
- Skip flags and key are sampled only at acceptance. Later changes on in_* have no effect.

## Timing
- Acceptance at edge N:
  - skip_mix=1: out_valid=1 in the cycle after edge N.
  - skip_mix=0: out_valid=1 in the cycle after edge N+4.
- Output handshake completes at edge M. in_ready=1 in the cycle after M. Peak rate is one block per 2 cycles (skip_mix) or 6 cycles (mix).
- out_data and out_valid hold stable while out_valid && !out_ready.
- in_valid while busy is ignored and the block is not consumed. The source must hold it.
- Reset state:
  - FSM in IDLE, col=0, work=0.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst=1 and 1 from the first cycle after rst deasserts.
- rst mid-BUSY or mid-DONE discards the block. No output is produced.
- rst takes priority over any simultaneous handshake.

## Structure
- Package aes_pkg holds:
  - gf_xtime function and the 9/11/13/14 multiply functions
  - byte/column index helper
  - FSM state enum (IDLE/BUSY/DONE)
- Sub-module aes_inv_mix_column: combinational, 32-bit column in, 32-bit column out. One instance, muxed by col.
- InvShiftRows is pure wiring inside the top module.

## Test plan
- Shift only: in_data=0x000102030405060708090a0b0c0d0e0f, key=0, skip_mix=1, skip_shift=0 -> out_data=0x000d0a07_04010e0b_0805020f_0c090603, one cycle after acceptance.
- Mix only: all four columns 0x8e4da1bc, key=0, skip_mix=0, skip_shift=1 -> every column 0xdb135345, out_valid after edge N+4.
- Full path: in_data=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6, key=0, no skips -> 0xdbc6015c_f213c601_010a53c6_c6012245.
- Key add: in_data=0, key=0x000102...0f, both skips -> out_data equals the key, one cycle latency.
- Backpressure: out_ready low for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0, a second in_valid is not consumed. Release -> handshake, then the second block is accepted the next cycle.
- Reset mid-BUSY at col=2 -> the next cycle shows out_valid=0, out_data=0, in_ready=1 after release, and no stale output ever appears.
